mux4_sel_arbiter: RTL and testbench

Round-robin select generator that drives the 2-bit select input of the 4:1 one-bit multiplexer stage. It arbitrates between four channel request lines and holds each granted channel on `S` for a bounded dwell time. It then rotates to the next requester, so the mux output time-shares fairly across X0..X3. It sits directly upstream of the mux. `S` connects straight to the mux select, and `valid` qualifies the mux output `Z` for downstream logic.

---
 rtl/mux4_sel_arbiter.sv | 110 +++++++++++
 tb/tb_mux4_sel_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mux4_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux.
// Grants a requesting channel on S for at most DWELL cycles, then rotates.
module mux4_sel_arbiter #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] S,
    output logic [3:0] grant,
    output logic       valid,
    output logic       new_grant
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    s_q, s_d;
    logic [3:0]    grant_q, grant_d;
    logic          valid_q, valid_d;
    logic          new_grant_q, new_grant_d;

    logic [1:0]    win;
    logic [1:0]    idx;
    logic          found;
    logic          release_c;
    logic          load;

    // Scan last+1 .. last+4 so the previous owner has lowest priority.
    always_comb begin
        win   = last_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign release_c = (cnt_q == '0) || done || !req[s_q] || !en;
    assign load      = en && found && ((state_q == IDLE) || release_c);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 2'b11;
            cnt_q       <= '0;
            s_q         <= 2'b00;
            grant_q     <= 4'b0000;
            valid_q     <= 1'b0;
            new_grant_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            grant_q     <= grant_d;
            valid_q     <= valid_d;
            new_grant_q <= new_grant_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = GRANT;
            GRANT:   if (release_c && !load) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_comb begin
        last_d      = last_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        grant_d     = grant_q;
        valid_d     = valid_q;
        new_grant_d = 1'b0;
        if (load) begin
            last_d      = win;
            cnt_d       = CW'(DWELL - 1);
            s_d         = win;
            grant_d     = 4'b0001 << win;
            valid_d     = 1'b1;
            new_grant_d = 1'b1;
        end else if (state_q == GRANT && !release_c) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            grant_d = 4'b0000;
            valid_d = 1'b0;
        end
    end

    assign S         = s_q;
    assign grant     = grant_q;
    assign valid     = valid_q;
    assign new_grant = new_grant_q;

endmodule

// File: tb/tb_mux4_sel_arbiter.sv
// Self-checking bench for mux4_sel_arbiter.
// Directed test-plan steps followed by randomized traffic against a reference model.
module tb_mux4_sel_arbiter;

    localparam int DWELL = 4;
    localparam int CW    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [1:0] S;
    logic [3:0] grant;
    logic       valid;
    logic       new_grant;

    int checks = 0;
    int errors = 0;

    // Reference model: owner channel and how many cycles it has held the grant
    bit m_valid;
    int m_ch;
    int m_age;
    int m_last;
    int m_s;
    bit m_ng;

    mux4_sel_arbiter #(.DWELL(DWELL), .CW(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
        .S(S), .grant(grant), .valid(valid), .new_grant(new_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_ch = 0; m_age = 0; m_last = 3; m_s = 0; m_ng = 0;
    endtask

    task automatic model_step();
        bit rel;
        int c;
        rel = !m_valid || (m_age >= DWELL - 1) || done || !req[m_ch] || !en;
        if (!rel) begin
            m_age++;
            m_ng = 0;
        end else if (en && req != 0) begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (req[c]) break;
            end
            m_ch = c; m_s = c; m_last = c; m_age = 0; m_valid = 1; m_ng = 1;
        end else begin
            m_valid = 0;
            m_ng = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".S"}, 32'(S), 32'(m_s));
        check({tag, ".grant"}, 32'(grant), m_valid ? (32'd1 << m_ch) : 32'd0);
        check({tag, ".valid"}, 32'(valid), 32'(m_valid));
        check({tag, ".new_grant"}, 32'(new_grant), 32'(m_ng));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; req = '0; done = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // All channels requesting: 0,1,2,3,0 each for DWELL cycles
        en = 1'b1; req = 4'b1111;
        step("first");
        check("first.S0", 32'(S), 32'd0);
        check("first.ng", 32'(new_grant), 32'd1);
        for (int i = 0; i < 19; i++) step("rr1111");
        check("rr.S_wrap", 32'(S), 32'd0);

        // Single requester re-granted back to back
        req = 4'b0100;
        for (int i = 0; i < 12; i++) step("single2");
        check("single2.valid", 32'(valid), 32'd1);

        // done in the second cycle of channel 0's grant
        req = 4'b0011;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            done = (m_valid && m_ch == 0 && m_age == 1 && n == 0);
            if (done) n = 1;
            step("done0011");
        end
        done = 1'b0;

        // Channel 3 alone, then drop its request
        req = 4'b1000;
        n = 0;
        while (!(m_valid && m_ch == 3) && n < 12) begin
            step("wait3");
            n++;
        end
        check("wait3.timeout", 32'(m_valid && m_ch == 3), 32'd1);
        req = 4'b0000;
        step("drop3");
        check("drop3.valid", 32'(valid), 32'd0);
        check("drop3.grant", 32'(grant), 32'd0);
        step("idle");
        req = 4'b1001;
        step("after3");
        check("after3.S", 32'(S), 32'd0);

        // en drop mid-grant, then resume
        req = 4'b1111;
        step("en_a");
        step("en_b");
        en = 1'b0;
        for (int i = 0; i < 4; i++) step("en_low");
        check("en_low.valid", 32'(valid), 32'd0);
        en = 1'b1;
        for (int i = 0; i < 6; i++) step("en_resume");

        // Asynchronous reset mid-grant
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #3;
        rst = 1'b0;
        step("post_rst");
        check("post_rst.S", 32'(S), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) req = req | (4'b0001 << m_ch);
            en   = ($urandom_range(0, 9) != 0);
            done = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
